// File: rtl/timer_pkg.sv
// timer_pkg
//   Shared constants for the timer compare unit: register byte offsets,
//   CTRL bit positions and the compare register reset value.
//   Build option: TIMER_CMP_PERIODIC_EN enables the PERIOD register and
//   periodic auto-advance in the modules that import this package.
package timer_pkg;

  localparam logic [3:0] TMR_OFS_CMP_LO = 4'h0;
  localparam logic [3:0] TMR_OFS_CMP_HI = 4'h4;
  localparam logic [3:0] TMR_OFS_CTRL   = 4'h8;
  localparam logic [3:0] TMR_OFS_PERIOD = 4'hC;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int CTRL_PEND_BIT     = 8;

  localparam logic [63:0] CMP_RESET_VAL = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/timer_cmp64_regs.sv
// timer_cmp64_regs
//   Register file of the 64-bit compare unit: compare shadow/commit, CTRL
//   bits, optional PERIOD register and the registered read mux.
//   Build option: TIMER_CMP_PERIODIC_EN (PERIOD register and PERIODIC bit).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wen, ren, addr_ofs    bus write/read strobes and byte offset
//   data_i                write data
//   pend_set              hardware match, sets PEND
//   en_clr                one-shot match, clears EN
//   adv_valid, adv_cmp    periodic advance request and the advanced compare
//   period                PERIOD register (periodic build only)
//   cmp, en, periodic     committed compare value and CTRL bits
//   pend                  pending flag
//   data_o                registered read data
module timer_cmp64_regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wen,
  input  logic        ren,
  input  logic [3:0]  addr_ofs,
  input  logic [31:0] data_i,
  input  logic        pend_set,
  input  logic        en_clr,
  input  logic        adv_valid,
  input  logic [63:0] adv_cmp,
`ifdef TIMER_CMP_PERIODIC_EN
  output logic [31:0] period,
`endif
  output logic [63:0] cmp,
  output logic        en,
  output logic        periodic,
  output logic        pend,
  output logic [31:0] data_o
);
  import timer_pkg::*;

  logic [31:0] cmp_lo_shd;
  logic [31:0] rdata;
  logic        wr_lo;
  logic        wr_hi;
  logic        wr_ctrl;

  assign wr_lo   = wen && (addr_ofs == TMR_OFS_CMP_LO);
  assign wr_hi   = wen && (addr_ofs == TMR_OFS_CMP_HI);
  assign wr_ctrl = wen && (addr_ofs == TMR_OFS_CTRL);

  // The low word is only staged; the high-word write commits both halves
  // together so the comparator never sees a half-updated compare value.
  // A software commit overrides a same-cycle periodic advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_lo_shd <= '0;
      cmp        <= CMP_RESET_VAL;
    end else begin
      if (wr_lo)
        cmp_lo_shd <= data_i;
      if (wr_hi)
        cmp <= {data_i, cmp_lo_shd};
      else if (adv_valid)
        cmp <= adv_cmp;
    end
  end

  // Software CTRL write beats the one-shot EN clear; a match beats a
  // software PEND clear so an event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en   <= 1'b0;
      pend <= 1'b0;
    end else begin
      if (wr_ctrl)
        en <= data_i[CTRL_EN_BIT];
      else if (en_clr)
        en <= 1'b0;
      if (pend_set)
        pend <= 1'b1;
      else if (wr_ctrl && data_i[CTRL_PEND_BIT])
        pend <= 1'b0;
    end
  end

`ifdef TIMER_CMP_PERIODIC_EN
  logic wr_per;
  assign wr_per = wen && (addr_ofs == TMR_OFS_PERIOD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      periodic <= 1'b0;
      period   <= '0;
    end else begin
      if (wr_ctrl)
        periodic <= data_i[CTRL_PERIODIC_BIT];
      if (wr_per)
        period <= data_i;
    end
  end
`else
  assign periodic = 1'b0;
`endif

  // Read mux uses the pre-edge register values, so a same-cycle write to
  // the register being read is not visible in this read.
  always_comb begin
    rdata = '0;
    case (addr_ofs)
      TMR_OFS_CMP_LO: rdata = cmp[31:0];
      TMR_OFS_CMP_HI: rdata = cmp[63:32];
      TMR_OFS_CTRL: begin
        rdata[CTRL_EN_BIT]       = en;
        rdata[CTRL_PERIODIC_BIT] = periodic;
        rdata[CTRL_PEND_BIT]     = pend;
      end
`ifdef TIMER_CMP_PERIODIC_EN
      TMR_OFS_PERIOD: rdata = period;
`endif
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      data_o <= '0;
    else
      data_o <= ren ? rdata : 32'd0;
  end

endmodule

// File: rtl/timer_cmp64.sv
// timer_cmp64
//   Memory-mapped 64-bit compare/interrupt unit beside the free-running
//   64-bit timer. Raises a level interrupt when the timer count reaches the
//   committed compare value; optionally re-arms by adding PERIOD.
//   Build option: TIMER_CMP_PERIODIC_EN (PERIOD register, PERIODIC bit and
//   the 64-bit advance adder). Without it every match is one-shot.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wen, ren              register write/read strobes
//   addr_ofs              register byte offset (0x0,0x4,0x8,0xC)
//   data_i                write data
//   time_i                current timer count (same clock domain)
//   data_o                registered read data (one cycle after ren)
//   irq_o                 level interrupt, equal to PEND
module timer_cmp64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wen,
  input  logic        ren,
  input  logic [3:0]  addr_ofs,
  input  logic [31:0] data_i,
  input  logic [63:0] time_i,
  output logic [31:0] data_o,
  output logic        irq_o
);
  import timer_pkg::*;

  logic [63:0] cmp;
  logic [63:0] adv_cmp;
  logic        en;
  logic        periodic;
  logic        pend;
  logic        match;
  logic        adv_valid;
  logic        en_clr;
`ifdef TIMER_CMP_PERIODIC_EN
  logic [31:0] period;
`endif

  timer_cmp64_regs u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .wen       (wen),
    .ren       (ren),
    .addr_ofs  (addr_ofs),
    .data_i    (data_i),
    .pend_set  (match),
    .en_clr    (en_clr),
    .adv_valid (adv_valid),
    .adv_cmp   (adv_cmp),
`ifdef TIMER_CMP_PERIODIC_EN
    .period    (period),
`endif
    .cmp       (cmp),
    .en        (en),
    .periodic  (periodic),
    .pend      (pend),
    .data_o    (data_o)
  );

  assign match = en && (time_i >= cmp);

  // Advance wraps mod 2^64; PERIOD = 0 leaves cmp in place so the unit
  // matches every cycle while enabled.
`ifdef TIMER_CMP_PERIODIC_EN
  assign adv_cmp = cmp + {32'd0, period};
`else
  assign adv_cmp = cmp;
`endif

  assign adv_valid = match && periodic;
  assign en_clr    = match && !periodic;
  assign irq_o     = pend;

endmodule

// File: tb/tb_timer_cmp64.sv
// tb_timer_cmp64
//   Self-checking bench for timer_cmp64: directed scenarios plus a random
//   phase, all compared against a cycle-level behavioural model of the
//   register/compare rules. Periodic scenarios are built only when
//   TIMER_CMP_PERIODIC_EN is defined; the model follows the same option.
module tb_timer_cmp64;

`ifdef TIMER_CMP_PERIODIC_EN
  localparam bit HAS_PER = 1'b1;
`else
  localparam bit HAS_PER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wen;
  logic        ren;
  logic [3:0]  addr_ofs;
  logic [31:0] data_i;
  logic [63:0] time_i;
  logic [31:0] data_o;
  logic        irq_o;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  logic [63:0] mCmp;
  logic [31:0] mShd;
  logic [31:0] mPeriod;
  logic [31:0] mData;
  logic        mEn;
  logic        mPer;
  logic        mPend;

  // random phase scratch
  logic [3:0]  addrTab [6];
  logic [3:0]  rAddr;
  logic [31:0] rData;
  logic [63:0] tCur;
  logic        rWen;
  logic        rRen;

  always #5 clk = ~clk;

  timer_cmp64 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wen      (wen),
    .ren      (ren),
    .addr_ofs (addr_ofs),
    .data_i   (data_i),
    .time_i   (time_i),
    .data_o   (data_o),
    .irq_o    (irq_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mCmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    mShd    = 32'd0;
    mPeriod = 32'd0;
    mData   = 32'd0;
    mEn     = 1'b0;
    mPer    = 1'b0;
    mPend   = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using the inputs currently
  // driven and the pre-edge model state.
  task automatic modelStep();
    bit          hit;
    logic [31:0] rv;
    logic [63:0] oldCmp;
    logic [31:0] oldShd;
    hit    = mEn && (time_i >= mCmp);
    oldCmp = mCmp;
    oldShd = mShd;
    case (addr_ofs)
      4'h0:    rv = oldCmp[31:0];
      4'h4:    rv = oldCmp[63:32];
      4'h8:    rv = (mPend ? 32'd256 : 32'd0) + (mPer ? 32'd2 : 32'd0) + (mEn ? 32'd1 : 32'd0);
      4'hC:    rv = mPeriod;
      default: rv = 32'd0;
    endcase
    mData = ren ? rv : 32'd0;
    if (wen && addr_ofs == 4'h4)
      mCmp = {data_i, oldShd};
    else if (hit && mPer)
      mCmp = oldCmp + 64'(mPeriod);
    if (wen && addr_ofs == 4'h0)
      mShd = data_i;
    if (hit)
      mPend = 1'b1;
    else if (wen && addr_ofs == 4'h8 && data_i[8])
      mPend = 1'b0;
    if (wen && addr_ofs == 4'h8) begin
      mEn = data_i[0];
      if (HAS_PER)
        mPer = data_i[1];
    end else if (hit && !mPer) begin
      mEn = 1'b0;
    end
    if (HAS_PER && wen && addr_ofs == 4'hC)
      mPeriod = data_i;
  endtask

  // Drive one cycle of bus/timer inputs, advance the model at the edge and
  // compare irq_o and data_o on the following falling edge.
  task automatic applyStimulus(input logic w, input logic r, input logic [3:0] a,
                               input logic [31:0] d, input logic [63:0] t);
    wen      = w;
    ren      = r;
    addr_ofs = a;
    data_i   = d;
    time_i   = t;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput("irq", 64'(irq_o), 64'(mPend));
    checkOutput("rdata", 64'(data_o), 64'(mData));
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [63:0] t);
    applyStimulus(1'b1, 1'b0, a, d, t);
  endtask

  task automatic rd(input logic [3:0] a, input logic [63:0] t);
    applyStimulus(1'b0, 1'b1, a, 32'd0, t);
  endtask

  task automatic idle(input logic [63:0] t);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'd0, t);
  endtask

  initial begin
    addrTab = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h2, 4'h7};
    rst_n    = 1'b0;
    wen      = 1'b0;
    ren      = 1'b0;
    addr_ofs = 4'h0;
    data_i   = 32'd0;
    time_i   = 64'd0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_irq", 64'(irq_o), 64'd0);
    checkOutput("reset_data", 64'(data_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] reset read");
    rd(4'h0, 0);
    checkOutput("reset_cmp_lo", 64'(data_o), 64'hFFFF_FFFF);

    $display("[TB] one-shot");
    wr(4'h0, 100, 0);
    wr(4'h4, 0, 0);
    wr(4'h8, 32'h1, 0);
    for (int t = 90; t < 100; t++) idle(64'(t));
    checkOutput("oneshot_before", 64'(irq_o), 64'd0);
    idle(100);
    checkOutput("oneshot_irq", 64'(irq_o), 64'd1);
    rd(4'h8, 101);
    checkOutput("oneshot_ctrl", 64'(data_o), 64'h100);
    wr(4'h8, 32'h100, 102);
    checkOutput("oneshot_clear", 64'(irq_o), 64'd0);

    $display("[TB] torn-write guard");
    wr(4'h0, 50, 0);
    wr(4'h4, 0, 0);
    wr(4'h8, 32'h101, 60);
    wr(4'h0, 1000, 60);
    checkOutput("torn_oldcmp", 64'(irq_o), 64'd1);
    wr(4'h4, 0, 60);
    wr(4'h8, 32'h101, 60);
    checkOutput("torn_cleared", 64'(irq_o), 64'd0);
    idle(60);
    idle(999);
    checkOutput("torn_999", 64'(irq_o), 64'd0);
    idle(1000);
    checkOutput("torn_1000", 64'(irq_o), 64'd1);

    $display("[TB] clear/match collision");
    wr(4'h0, 200, 0);
    wr(4'h4, 0, 0);
    wr(4'h8, 32'h101, 0);
    wr(4'h8, 32'h100, 200);
    checkOutput("coll_pend", 64'(irq_o), 64'd1);
    rd(4'h8, 200);
    checkOutput("coll_ctrl", 64'(data_o), 64'h100);

    $display("[TB] asynchronous reset");
    rst_n = 1'b0;
    wen   = 1'b0;
    ren   = 1'b0;
    #1;
    checkOutput("arst_irq", 64'(irq_o), 64'd0);
    checkOutput("arst_data", 64'(data_o), 64'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    rd(4'h4, 0);
    checkOutput("arst_cmp_hi", 64'(data_o), 64'hFFFF_FFFF);
    rd(4'h8, 0);

`ifdef TIMER_CMP_PERIODIC_EN
    $display("[TB] periodic");
    wr(4'hC, 10, 0);
    wr(4'h0, 20, 0);
    wr(4'h4, 0, 0);
    wr(4'h8, 32'h103, 15);
    for (int t = 16; t <= 50; t++) begin
      rd(4'h0, 64'(t));
      if (t == 21) checkOutput("per_cmp30", 64'(data_o), 64'd30);
      if (t == 31) checkOutput("per_cmp40", 64'(data_o), 64'd40);
      if (t == 41) checkOutput("per_cmp50", 64'(data_o), 64'd50);
    end

    $display("[TB] wrap");
    wr(4'hC, 8, 0);
    wr(4'h0, 32'hFFFF_FFFC, 0);
    wr(4'h4, 32'hFFFF_FFFF, 0);
    wr(4'h8, 32'h103, 0);
    idle(64'hFFFF_FFFF_FFFF_FFFC);
    rd(4'h4, 0);
    checkOutput("wrap_hi", 64'(data_o), 64'd0);
    rd(4'h0, 0);
    checkOutput("wrap_lo", 64'(data_o), 64'd4);

    $display("[TB] commit/advance collision");
    wr(4'hC, 5, 0);
    wr(4'h0, 300, 0);
    wr(4'h4, 0, 0);
    wr(4'h0, 777, 0);
    wr(4'h8, 32'h103, 0);
    wr(4'h4, 0, 300);
    rd(4'h0, 0);
    checkOutput("coll_commit", 64'(data_o), 64'd777);
`endif

    $display("[TB] random phase");
    tCur = 64'd0;
    for (int i = 0; i < 600; i++) begin
      rWen  = ($urandom_range(0, 2) == 0);
      rRen  = ($urandom_range(0, 1) == 0);
      rAddr = addrTab[$urandom_range(0, 5)];
      case (rAddr)
        4'h0:    rData = $urandom_range(0, 300);
        4'h4:    rData = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
        4'hC:    rData = $urandom_range(0, 15);
        default: rData = $urandom;
      endcase
      tCur = tCur + 64'($urandom_range(0, 3));
      if (tCur > 400) tCur = 64'($urandom_range(0, 100));
      applyStimulus(rWen, rRen, rAddr, rData, tCur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
